// File: rtl/e203_expl_icb_arb.sv
// Two-master ICB arbiter in front of the expl AXI bridge: one outstanding transaction, round-robin grant.
// Optional response timeout with ERR/stale handling is enabled by defining E203_EXPL_ARB_TMO_EN.
module e203_expl_icb_arb #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_icb_cmd_valid,
  output logic        m0_icb_cmd_ready,
  input  logic [31:0] m0_icb_cmd_addr,
  input  logic        m0_icb_cmd_read,
  input  logic [31:0] m0_icb_cmd_wdata,
  input  logic [3:0]  m0_icb_cmd_wmask,
  output logic        m0_icb_rsp_valid,
  output logic        m0_icb_rsp_err,
  output logic [31:0] m0_icb_rsp_rdata,
  input  logic        m0_icb_rsp_ready,
  input  logic        m1_icb_cmd_valid,
  output logic        m1_icb_cmd_ready,
  input  logic [31:0] m1_icb_cmd_addr,
  input  logic        m1_icb_cmd_read,
  input  logic [31:0] m1_icb_cmd_wdata,
  input  logic [3:0]  m1_icb_cmd_wmask,
  output logic        m1_icb_rsp_valid,
  output logic        m1_icb_rsp_err,
  output logic [31:0] m1_icb_rsp_rdata,
  input  logic        m1_icb_rsp_ready,
  output logic        s_icb_cmd_valid,
  input  logic        s_icb_cmd_ready,
  output logic [31:0] s_icb_cmd_addr,
  output logic        s_icb_cmd_read,
  output logic [31:0] s_icb_cmd_wdata,
  output logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_rsp_valid,
  input  logic        s_icb_rsp_err,
  input  logic [31:0] s_icb_rsp_rdata,
  output logic        s_icb_rsp_ready,
  output logic        tmo_flag
);

`ifdef E203_EXPL_ARB_TMO_EN
  typedef enum logic [1:0] {IDLE, CMD, RSP, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
`endif

  state_t state;
  logic   grant;
  logic   rr_ptr;
  logic   next_grant;
  logic   g_cmd_valid;
  logic   g_rsp_ready;
  logic   cmd_hs;
  logic   rsp_hs;
  logic   any_req;
  logic   stale_blk;

`ifdef E203_EXPL_ARB_TMO_EN
  logic       stale;
  logic [7:0] tmo_cnt;
  assign stale_blk = stale;
`else
  assign stale_blk = 1'b0;
  assign tmo_flag  = 1'b0;
`endif

  assign any_req     = m0_icb_cmd_valid | m1_icb_cmd_valid;
  // Rotate only on contention; a lone requester always wins.
  assign next_grant  = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? rr_ptr : m1_icb_cmd_valid;
  assign g_cmd_valid = grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign g_rsp_ready = grant ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  assign cmd_hs      = (state == CMD) & g_cmd_valid & s_icb_cmd_ready;
  assign rsp_hs      = (state == RSP) & s_icb_rsp_valid & g_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 1'b0;
      rr_ptr <= 1'b0;
`ifdef E203_EXPL_ARB_TMO_EN
      stale    <= 1'b0;
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
`endif
    end else begin
`ifdef E203_EXPL_ARB_TMO_EN
      // The abandoned response may show up later; swallow it before re-arming.
      if (stale && s_icb_rsp_valid && (state != RSP))
        stale <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req && !stale_blk) begin
            grant <= next_grant;
            state <= CMD;
          end
        end
        CMD: begin
          if (cmd_hs) begin
            state <= RSP;
`ifdef E203_EXPL_ARB_TMO_EN
            tmo_cnt <= '0;
`endif
          end
        end
        RSP: begin
          if (rsp_hs) begin
            state  <= IDLE;
            rr_ptr <= ~grant;
          end
`ifdef E203_EXPL_ARB_TMO_EN
          else if (!s_icb_rsp_valid) begin
            if (tmo_cnt != 8'hFF)
              tmo_cnt <= tmo_cnt + 8'd1;
            if (({24'd0, tmo_cnt} + 32'd1) >= TMO_CYCLES) begin
              state    <= ERR;
              stale    <= 1'b1;
              tmo_flag <= 1'b1;
            end
          end
`endif
        end
`ifdef E203_EXPL_ARB_TMO_EN
        ERR: begin
          if (g_rsp_ready) begin
            state  <= IDLE;
            rr_ptr <= ~grant;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_icb_cmd_valid  = 1'b0;
    s_icb_cmd_addr   = '0;
    s_icb_cmd_read   = 1'b0;
    s_icb_cmd_wdata  = '0;
    s_icb_cmd_wmask  = '0;
    s_icb_rsp_ready  = 1'b0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    m0_icb_rsp_valid = 1'b0;
    m0_icb_rsp_err   = 1'b0;
    m0_icb_rsp_rdata = '0;
    m1_icb_rsp_valid = 1'b0;
    m1_icb_rsp_err   = 1'b0;
    m1_icb_rsp_rdata = '0;
    if (!rst) begin
      case (state)
        CMD: begin
          s_icb_cmd_valid = g_cmd_valid;
          if (grant) begin
            s_icb_cmd_addr   = m1_icb_cmd_addr;
            s_icb_cmd_read   = m1_icb_cmd_read;
            s_icb_cmd_wdata  = m1_icb_cmd_wdata;
            s_icb_cmd_wmask  = m1_icb_cmd_wmask;
            m1_icb_cmd_ready = s_icb_cmd_ready;
          end else begin
            s_icb_cmd_addr   = m0_icb_cmd_addr;
            s_icb_cmd_read   = m0_icb_cmd_read;
            s_icb_cmd_wdata  = m0_icb_cmd_wdata;
            s_icb_cmd_wmask  = m0_icb_cmd_wmask;
            m0_icb_cmd_ready = s_icb_cmd_ready;
          end
        end
        RSP: begin
          s_icb_rsp_ready = g_rsp_ready;
          if (grant) begin
            m1_icb_rsp_valid = s_icb_rsp_valid;
            m1_icb_rsp_err   = s_icb_rsp_err;
            m1_icb_rsp_rdata = s_icb_rsp_rdata;
          end else begin
            m0_icb_rsp_valid = s_icb_rsp_valid;
            m0_icb_rsp_err   = s_icb_rsp_err;
            m0_icb_rsp_rdata = s_icb_rsp_rdata;
          end
        end
`ifdef E203_EXPL_ARB_TMO_EN
        ERR: begin
          if (grant) begin
            m1_icb_rsp_valid = 1'b1;
            m1_icb_rsp_err   = 1'b1;
          end else begin
            m0_icb_rsp_valid = 1'b1;
            m0_icb_rsp_err   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      if (stale_blk && (state != RSP))
        s_icb_rsp_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_e203_expl_icb_arb.sv
// Scoreboard bench for e203_expl_icb_arb: masters and target are modelled in one per-cycle loop,
// expected commands/responses are queued at issue time and popped on observed handshakes.
module tb_e203_expl_icb_arb;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mv, mrd, mready, mrv, merr, mrr;
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [3:0]  mwm [2];
  logic [31:0] mrdata [2];
  logic        s_cmd_valid, s_cmd_ready, s_read, s_rsp_valid, s_rsp_err, s_rsp_ready, tmo_flag;
  logic [31:0] s_addr, s_wd, s_rsp_rdata;
  logic [3:0]  s_wm;

  cmd_t q0[$], q1[$], expc[$];
  rsp_t r0[$], r1[$];
  cmd_t ld, ec;
  rsp_t er;
  logic [1:0]  acc = '0;
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, hs_cyc = 0, rsp0_cyc = 0, bp_seen = 0;
  int          tgt_bp = 0, tgt_cnt = 0;
  bit          tgt_silent = 0, tgt_err = 0, tgt_busy = 0, late_done = 1;
  logic [31:0] tgt_addr = '0;

  always #5 clk = ~clk;

  e203_expl_icb_arb #(.TMO_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(mv[0]), .m0_icb_cmd_ready(mready[0]), .m0_icb_cmd_addr(maddr[0]),
    .m0_icb_cmd_read(mrd[0]), .m0_icb_cmd_wdata(mwd[0]), .m0_icb_cmd_wmask(mwm[0]),
    .m0_icb_rsp_valid(mrv[0]), .m0_icb_rsp_err(merr[0]), .m0_icb_rsp_rdata(mrdata[0]),
    .m0_icb_rsp_ready(mrr[0]),
    .m1_icb_cmd_valid(mv[1]), .m1_icb_cmd_ready(mready[1]), .m1_icb_cmd_addr(maddr[1]),
    .m1_icb_cmd_read(mrd[1]), .m1_icb_cmd_wdata(mwd[1]), .m1_icb_cmd_wmask(mwm[1]),
    .m1_icb_rsp_valid(mrv[1]), .m1_icb_rsp_err(merr[1]), .m1_icb_rsp_rdata(mrdata[1]),
    .m1_icb_rsp_ready(mrr[1]),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready), .s_icb_cmd_addr(s_addr),
    .s_icb_cmd_read(s_read), .s_icb_cmd_wdata(s_wd), .s_icb_cmd_wmask(s_wm),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_err(s_rsp_err), .s_icb_rsp_rdata(s_rsp_rdata),
    .s_icb_rsp_ready(s_rsp_ready),
    .tmo_flag(tmo_flag)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hCEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic issue(input logic id, input logic [31:0] addr, input logic rdn,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic want_rsp, input logic [31:0] erd, input logic eerr);
    cmd_t c;
    rsp_t r;
    c.id = id; c.addr = addr; c.read = rdn; c.wdata = wd; c.wmask = wm;
    if (id) q1.push_back(c); else q0.push_back(c);
    expc.push_back(c);
    if (want_rsp) begin
      r.rdata = erd; r.err = eerr;
      if (id) r1.push_back(r); else r0.push_back(r);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || expc.size() != 0 || r0.size() != 0 ||
            r1.size() != 0 || mv != 2'b00) && n < budget) begin
      @(negedge clk); #3; n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n = 0;
    while (!tgt_busy && n < budget) begin
      @(negedge clk); #3; n++;
    end
    check(tag, 32'(tgt_busy), 32'd1);
  endtask

  // Per-cycle master/target model: drive on negedge, sample 4 time units later (before posedge).
  initial begin
    mv = '0; mrd = '0; mrr = 2'b11;
    maddr[0] = '0; maddr[1] = '0; mwd[0] = '0; mwd[1] = '0; mwm[0] = '0; mwm[1] = '0;
    s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_err = 1'b0; s_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (acc[0]) mv[0] = 1'b0;
      if (acc[1]) mv[1] = 1'b0;
      acc = '0;
      if (!rst && !mv[0] && q0.size() != 0) begin
        ld = q0.pop_front();
        mv[0] = 1'b1; maddr[0] = ld.addr; mrd[0] = ld.read; mwd[0] = ld.wdata; mwm[0] = ld.wmask;
      end
      if (!rst && !mv[1] && q1.size() != 0) begin
        ld = q1.pop_front();
        mv[1] = 1'b1; maddr[1] = ld.addr; mrd[1] = ld.read; mwd[1] = ld.wdata; mwm[1] = ld.wmask;
      end
      s_cmd_ready = (tgt_bp == 0);
      if (tgt_busy && !tgt_silent && tgt_cnt == 0) begin
        s_rsp_valid = 1'b1; s_rsp_err = tgt_err; s_rsp_rdata = rd(tgt_addr);
      end else begin
        s_rsp_valid = 1'b0; s_rsp_err = 1'b0; s_rsp_rdata = '0;
      end
      #4;
      if (s_cmd_valid && !s_cmd_ready && expc.size() != 0) begin
        bp_seen++;
        check("bp_addr", s_addr, expc[0].addr);
        check("bp_wdata", s_wd, expc[0].wdata);
        check("bp_wmask", {28'd0, s_wm}, {28'd0, expc[0].wmask});
        check("bp_ready", {30'd0, mready}, 32'd0);
      end
      if (s_cmd_valid && tgt_bp > 0) tgt_bp--;
      if (s_cmd_valid && s_cmd_ready) begin
        check("cmd_expected", 32'(expc.size() != 0), 32'd1);
        if (expc.size() != 0) begin
          ec = expc.pop_front();
          check("cmd_master", {31'd0, mready[1]}, {31'd0, ec.id});
          check("cmd_addr", s_addr, ec.addr);
          check("cmd_read", {31'd0, s_read}, {31'd0, ec.read});
          check("cmd_wdata", s_wd, ec.wdata);
          check("cmd_wmask", {28'd0, s_wm}, {28'd0, ec.wmask});
          check("cmd_while_rsp", 32'(tgt_busy), 32'd0);
          check("cmd_before_late", 32'(late_done), 32'd1);
        end
        acc = mready & mv;
        tgt_busy = 1'b1; tgt_cnt = 0; tgt_addr = s_addr; hs_cyc = cyc;
      end else if (tgt_busy && tgt_cnt > 0) begin
        tgt_cnt--;
      end
      if (s_rsp_valid && s_rsp_ready) tgt_busy = 1'b0;
      if (mrv[0] && mrr[0]) begin
        rsp0_cyc = cyc;
        check("rsp0_expected", 32'(r0.size() != 0), 32'd1);
        if (r0.size() != 0) begin
          er = r0.pop_front();
          check("rsp0_rdata", mrdata[0], er.rdata);
          check("rsp0_err", {31'd0, merr[0]}, {31'd0, er.err});
          check("rsp0_other_valid", {31'd0, mrv[1]}, 32'd0);
        end
      end
      if (mrv[1] && mrr[1]) begin
        check("rsp1_expected", 32'(r1.size() != 0), 32'd1);
        if (r1.size() != 0) begin
          er = r1.pop_front();
          check("rsp1_rdata", mrdata[1], er.rdata);
          check("rsp1_err", {31'd0, merr[1]}, {31'd0, er.err});
          check("rsp1_other_valid", {31'd0, mrv[0]}, 32'd0);
        end
      end
    end
  end

  initial begin
    // Both masters queued during reset: expect strict alternation starting at m0.
    for (int unsigned i = 0; i < 4; i++) begin
      issue(1'b0, 32'h2000_0000 + 32'(i * 4), 1'b1, '0, '0, 1'b1, rd(32'h2000_0000 + 32'(i * 4)), 1'b0);
      issue(1'b1, 32'h3000_0000 + 32'(i * 4), 1'b0, 32'hA000_0000 + 32'(i), 4'h3, 1'b1,
            rd(32'h3000_0000 + 32'(i * 4)), 1'b0);
    end
    repeat (2) @(negedge clk);
    #4;
    check("reset_ctrl", {25'd0, mready, mrv, s_cmd_valid, s_rsp_ready, tmo_flag}, 32'd0);
    check("reset_data", s_addr | s_wd | mrdata[0] | mrdata[1] | {28'd0, s_wm}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    wait_done("drain_alternate", 200);

    // Single m0 read with fixed payload.
    @(negedge clk); #2;
    issue(1'b0, 32'h1000_0000, 1'b1, '0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_done("drain_single", 50);

    // m1 write held off by 5 cycles of target backpressure.
    @(negedge clk); #2;
    bp_seen = 0; tgt_bp = 5;
    issue(1'b1, 32'h4000_0010, 1'b0, 32'h1234_5678, 4'hF, 1'b1, rd(32'h4000_0010), 1'b0);
    wait_done("drain_bp", 50);
    check("bp_cycles", 32'(bp_seen), 32'd5);

    // Target error passed through to m0; no timeout involved.
    @(negedge clk); #2;
    tgt_err = 1'b1;
    issue(1'b0, 32'h5000_0000, 1'b1, '0, '0, 1'b1, rd(32'h5000_0000), 1'b1);
    wait_done("drain_err", 50);
    @(negedge clk); #2;
    tgt_err = 1'b0;
    check("err_no_tmo", {31'd0, tmo_flag}, 32'd0);

    // Reset while m0 waits for a response: abandoned, then arbitration restarts at m0.
    tgt_silent = 1'b1;
    issue(1'b0, 32'h6000_0000, 1'b1, '0, '0, 1'b0, '0, 1'b0);
    wait_busy("rst_reach_rsp", 20);
    repeat (2) @(negedge clk);
    @(negedge clk); #1 rst = 1'b1;
    #3;
    check("midrst_ctrl", {25'd0, mready, mrv, s_cmd_valid, s_rsp_ready, tmo_flag}, 32'd0);
    check("midrst_data", s_addr | s_wd | mrdata[0] | mrdata[1] | {28'd0, s_wm}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    #1 tgt_busy = 1'b0; tgt_silent = 1'b0;
    issue(1'b0, 32'h6100_0000, 1'b1, '0, '0, 1'b1, rd(32'h6100_0000), 1'b0);
    issue(1'b1, 32'h6200_0000, 1'b1, '0, '0, 1'b1, rd(32'h6200_0000), 1'b0);
    wait_done("drain_after_rst", 50);

`ifdef E203_EXPL_ARB_TMO_EN
    // Silent target: m0 gets an error after 16 RSP cycles, late response is absorbed, then m1 runs.
    @(negedge clk); #2;
    tgt_silent = 1'b1;
    issue(1'b0, 32'h7000_0000, 1'b1, '0, '0, 1'b1, 32'h0000_0000, 1'b1);
    wait_busy("tmo_reach_rsp", 20);
    late_done = 1'b0;
    issue(1'b1, 32'h7100_0000, 1'b1, '0, '0, 1'b1, rd(32'h7100_0000), 1'b0);
    begin
      int n = 0;
      while (r0.size() != 0 && n < 60) begin
        @(negedge clk); #3; n++;
      end
      check("tmo_rsp_seen", 32'(n < 60), 32'd1);
    end
    check("tmo_latency", 32'(rsp0_cyc - hs_cyc), 32'd17);
    check("tmo_flag_set", {31'd0, tmo_flag}, 32'd1);
    repeat (4) begin
      @(negedge clk); #4;
      check("stale_no_grant", {30'd0, s_cmd_valid, mready[1]}, 32'd0);
    end
    tgt_silent = 1'b0;
    @(negedge clk); #4;
    check("late_absorbed", {31'd0, s_rsp_ready}, 32'd1);
    check("late_no_rsp", {30'd0, mrv}, 32'd0);
    late_done = 1'b1;
    wait_done("drain_tmo", 50);
    check("tmo_flag_sticky", {31'd0, tmo_flag}, 32'd1);
`else
    check("tmo_flag_tied", {31'd0, tmo_flag}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
